rf_wb_ctrl: RTL



---
 rtl/rf_ctrl_pkg.sv | 19 +
 rtl/rf_wb_ctrl_if.sv | 29 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/rf_wb_ctrl.sv | 68 ++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared constants and payload types for the register-file write-back controller.
package rf_ctrl_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned NREG   = 32;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned NREQ   = 3;
   localparam int unsigned PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam int unsigned REQ_ALU = 0;
   localparam int unsigned REQ_LSU = 1;
   localparam int unsigned REQ_CSR = 2;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_req_t;

endpackage

// File: rtl/rf_wb_ctrl_if.sv
// Bundle between execution units/decode and the write-back controller.
interface rf_wb_ctrl_if;
   import rf_ctrl_pkg::*;

   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ*REG_AW-1:0] req_rd;
   logic [NREQ*XLEN-1:0]   req_data;
   logic                   reg_write;
   logic [REG_AW-1:0]      rd_addr;
   logic [XLEN-1:0]        write_data;
   logic                   issue_valid;
   logic [REG_AW-1:0]      issue_rd;
   logic [REG_AW-1:0]      rs1_addr;
   logic [REG_AW-1:0]      rs2_addr;
   logic                   rs1_busy;
   logic                   rs2_busy;

   modport slave (
      input  req_valid, req_rd, req_data, issue_valid, issue_rd, rs1_addr, rs2_addr,
      output req_ready, reg_write, rd_addr, write_data, rs1_busy, rs2_busy
   );

   modport master (
      output req_valid, req_rd, req_data, issue_valid, issue_rd, rs1_addr, rs2_addr,
      input  req_ready, reg_write, rd_addr, write_data, rs1_busy, rs2_busy
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: priority starts at ptr and wraps modulo N.
module rr_arbiter #(
   parameter int unsigned N  = 3,
   parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  valid,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] winner
);

   logic          found;
   int unsigned   sum;
   logic [IW-1:0] idx;

   always_comb begin
      grant  = '0;
      winner = '0;
      found  = 1'b0;
      sum    = 0;
      idx    = '0;
      for (int unsigned k = 0; k < N; k++) begin
         sum = 32'(ptr) + k;
         if (sum >= N) sum = sum - N;
         idx = IW'(sum);
         if (!found && valid[idx]) begin
            found       = 1'b1;
            grant[idx]  = 1'b1;
            winner      = idx;
         end
      end
   end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Write-back controller: arbitrates the single register-file write port and
// tracks pending destination writes in a busy scoreboard for decode stalls.
module rf_wb_ctrl
   import rf_ctrl_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   rf_wb_ctrl_if.slave  bus
);

   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             we_q, we_d;
   wb_req_t          wr_q, wr_d;
   logic [NREG-1:0]  busy_q, busy_d;

   logic [NREQ-1:0]  grant;
   logic [PTR_W-1:0] winner;
   logic             hs;

   rr_arbiter #(.N(NREQ), .IW(PTR_W)) u_arb (
      .valid  (bus.req_valid),
      .ptr    (ptr_q),
      .grant  (grant),
      .winner (winner)
   );

   // Grant is suppressed during reset so nothing is accepted and lost.
   assign bus.req_ready = rst ? '0 : grant;
   assign hs            = |bus.req_ready;

   always_comb begin
      ptr_d  = ptr_q;
      we_d   = 1'b0;
      wr_d   = wr_q;
      busy_d = busy_q;
      if (hs) begin
         wr_d.rd   = bus.req_rd[32'(winner)*REG_AW +: REG_AW];
         wr_d.data = bus.req_data[32'(winner)*XLEN +: XLEN];
         we_d      = (wr_d.rd != '0);
         ptr_d     = (32'(winner) == NREQ - 1) ? '0 : winner + PTR_W'(1);
      end
      // Clear first so a same-edge issue to the same register keeps it busy.
      if (we_q) busy_d[wr_q.rd] = 1'b0;
      if (bus.issue_valid && (bus.issue_rd != '0)) busy_d[bus.issue_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q  <= '0;
         we_q   <= 1'b0;
         wr_q   <= '0;
         busy_q <= '0;
      end else begin
         ptr_q  <= ptr_d;
         we_q   <= we_d;
         wr_q   <= wr_d;
         busy_q <= busy_d;
      end
   end

   assign bus.reg_write  = we_q;
   assign bus.rd_addr    = wr_q.rd;
   assign bus.write_data = wr_q.data;
   assign bus.rs1_busy   = busy_q[bus.rs1_addr];
   assign bus.rs2_busy   = busy_q[bus.rs2_addr];

endmodule
